// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: active-low gfedcba
// glyphs for hex digits 0..F, the dark pattern and the PWM step count.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int BRIGHT_STEPS = 16;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    unique case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with blank slots, PWM
// brightness and frame-aligned buffered updates. Define SEG7_LZ_SUPPRESS_EN
// to enable leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int TICK_CYCLES = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            bright,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  data_vld,
  output logic                  data_rdy,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW   = $clog2(2 * DIGITS);
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP = TICK_CYCLES / BRIGHT_STEPS;

  logic [TW-1:0]       tcnt;
  logic [SW-1:0]       slot;
  logic                tick;
  logic                slot_last;
  logic                frame_wrap;
  logic                xfer;

  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, act_dp;
  logic [DIGITS-1:0]   pend_blank, act_blank;
  logic [DIGITS-1:0]   blank_eff;

  logic [DW-1:0]       digit_idx;
  logic [3:0]          nibble;
  logic [6:0]          pattern;
  logic [TW:0]         pwm_limit;
  logic                lit;

  assign tick       = (tcnt == TW'(TICK_CYCLES - 1));
  assign slot_last  = (slot == SW'(2 * DIGITS - 1));
  assign frame_wrap = tick && slot_last;
  assign xfer       = data_vld && data_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      slot <= '0;
    end else if (tick) begin
      tcnt <= '0;
      slot <= slot_last ? '0 : slot + 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Active loads the old pending contents at the wrap, so a same-cycle
  // transfer lands in pending and waits for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      data_rdy   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (frame_wrap) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (xfer) begin
        pend_data  <= data;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        data_rdy   <= 1'b0;
      end else if (frame_wrap) begin
        data_rdy <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] d,
                                                input logic [DIGITS-1:0]   p);
    logic sup;
    lz_mask = '0;
    sup     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (sup && d[4*i +: 4] == 4'h0 && !p[i]) lz_mask[i] = 1'b1;
      else sup = 1'b0;
    end
  endfunction

  assign blank_eff = act_blank | lz_mask(act_data, act_dp);
`else
  assign blank_eff = act_blank;
`endif

  assign digit_idx = DW'(DIGITS - 1) - DW'(slot >> 1);
  assign nibble    = act_data[{digit_idx, 2'b00} +: 4];
  assign pwm_limit = (TW + 1)'((32'(bright) + 32'd1) * 32'(STEP));
  assign lit       = en && !slot[0] && ({1'b0, tcnt} < pwm_limit) && !blank_eff[digit_idx];

  seg7_hex_decode u_decode (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // Anode, segments and dp share one register stage so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (lit) begin
      an  <= ~(DIGITS'(1) << digit_idx);
      seg <= pattern;
      dp  <= ~act_dp[digit_idx];
    end else begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-indexed reference model queues
// expected pin values at each rising edge, a monitor compares at falling edges.
module tb_seg7_scan_ctrl;

  localparam int D = 8;
  localparam int T = 16;
  localparam int FRAME = 2 * D * T;

  logic         clk = 1'b0;
  logic         rst, en, data_vld, data_rdy, dp, frame_done;
  logic [3:0]   bright;
  logic [31:0]  data;
  logic [7:0]   dp_in, blank_in, an;
  logic [6:0]   seg;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.DIGITS(D), .TICK_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bright     (bright),
    .data       (data),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .data_vld   (data_vld),
    .data_rdy   (data_rdy),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state: cycles since reset and the shown/pending contents.
  int          s;
  logic [31:0] m_act_data, m_pend_data;
  logic [7:0]  m_act_dp, m_pend_dp, m_act_blank, m_pend_blank;
  logic        m_rdy;

  // Digits above the highest nonzero-or-dotted digit are suppressed.
  function automatic logic [7:0] model_lz(input logic [31:0] d, input logic [7:0] p);
    int top = 0;
    for (int i = 0; i < D; i++)
      if (d[4*i +: 4] != 4'h0 || p[i]) top = i;
    model_lz = '0;
    for (int i = 0; i < D; i++)
      if (i > top) model_lz[i] = 1'b1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int tc, sl, dg;
    logic [7:0] beff;
    logic wrap, xfer;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, rdy: 1'b1};
    if (rst) begin
      s = 0;
      m_act_data = '0; m_act_dp = '0; m_act_blank = '0;
      m_pend_data = '0; m_pend_dp = '0; m_pend_blank = '0;
      m_rdy = 1'b1;
    end else begin
      tc = s % T;
      sl = (s / T) % (2 * D);
      dg = D - 1 - sl / 2;
      beff = m_act_blank;
`ifdef SEG7_LZ_SUPPRESS_EN
      beff = beff | model_lz(m_act_data, m_act_dp);
`endif
      if (en && (sl % 2 == 0) && tc < (int'(bright) + 1) * (T / 16) && !beff[dg]) begin
        e.an  = ~(8'd1 << dg);
        e.seg = hex_tbl[m_act_data[4*dg +: 4]];
        e.dp  = ~m_act_dp[dg];
      end
      wrap = (tc == T - 1) && (sl == 2 * D - 1);
      xfer = data_vld && m_rdy;
      e.fd = wrap;
      if (wrap) begin
        m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
      end
      if (xfer) begin
        m_pend_data = data; m_pend_dp = dp_in; m_pend_blank = blank_in;
        m_rdy = 1'b0;
      end else if (wrap) begin
        m_rdy = 1'b1;
      end
      e.rdy = m_rdy;
      s++;
    end
    q.push_back(e);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_output("pins", {16'h0, an, seg, dp}, {16'h0, e.an, e.seg, e.dp});
      check_output("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
      check_output("data_rdy", {31'h0, data_rdy}, {31'h0, e.rdy});
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
    @(negedge clk);
    data = d; dp_in = p; blank_in = b; data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; bright = 4'd15; data = '0; dp_in = '0; blank_in = '0;
    data_vld = 1'b0;
    run_cycles(3);
    rst = 1'b0;
    run_cycles(4);

    apply_stimulus(32'h0123_4567, 8'h00, 8'h00);
    run_cycles(2 * FRAME);

    bright = 4'd7;
    run_cycles(FRAME);
    bright = 4'd0;
    run_cycles(FRAME);
    bright = 4'd15;

    run_cycles(5 * T - (s % FRAME) % T);
    apply_stimulus(32'hFFFF_FFFF, 8'h00, 8'h00);
    run_cycles(20);
    apply_stimulus(32'hDEAD_BEEF, 8'h0F, 8'h00);
    run_cycles(2 * FRAME);

    apply_stimulus(32'h89AB_CDEF, 8'h80, 8'h01);
    run_cycles(FRAME + 40);
    en = 1'b0;
    run_cycles(FRAME);
    en = 1'b1;
    run_cycles(FRAME);

    apply_stimulus(32'h0000_0A00, 8'h00, 8'h00);
    run_cycles(2 * FRAME);
    apply_stimulus(32'h0000_0000, 8'h10, 8'h00);
    run_cycles(2 * FRAME);

    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      data_vld = ($urandom_range(0, 40) == 0);
      if (data_vld) begin
        data = ($urandom_range(0, 1) == 0) ? ($urandom() >> ($urandom_range(0, 7) * 4)) : $urandom();
        dp_in = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00;
        blank_in = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00;
      end
      if ($urandom_range(0, 100) == 0) bright = 4'($urandom());
      if ($urandom_range(0, 150) == 0) en = ~en;
      rst = (i >= 3000 && i < 3003);
    end
    data_vld = 1'b0; rst = 1'b0; en = 1'b1;
    run_cycles(FRAME);
    run_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
